// File: rtl/turfio_autotrain_pkg.sv
// Shared types for the TURFIO CIN auto-training sequencer.
// Holds the FSM state enum, fail codes and the IDELAY tap type.
package turfio_autotrain_pkg;

  typedef logic [8:0] tap_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_RST_CIN,
    S_SET_TAP,
    S_SETTLE,
    S_DWELL,
    S_NEXT_TAP,
    S_CENTER,
    S_CTR_SETTLE,
    S_SLIP_CAP,
    S_SLIP_CHK,
    S_SLIP_WAIT,
    S_LOCK,
    S_LOCK_WAIT,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [2:0] FAIL_NONE      = 3'd0;
  localparam logic [2:0] FAIL_NO_EYE    = 3'd1;
  localparam logic [2:0] FAIL_NO_PAT    = 3'd2;
  localparam logic [2:0] FAIL_NO_LOCK   = 3'd3;
  localparam logic [2:0] FAIL_LOCK_LOST = 3'd4;
  localparam logic [2:0] FAIL_ABORT     = 3'd5;

endpackage

// File: rtl/turfio_autotrain_eye.sv
// Eye tracker: longest run of good sweep points and where it began.
// Ties keep the earlier run, since only a strictly longer run replaces it.
module turfio_autotrain_eye
  import turfio_autotrain_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clr_i,
  input  logic       valid_i,
  input  logic       good_i,
  input  logic [8:0] tap_i,
  output logic [8:0] best_start_o,
  output logic [6:0] best_len_o
);

  logic [6:0] run_q;
  logic [6:0] best_q;
  tap_t       run_start_q;
  tap_t       best_start_q;
  logic [6:0] run_d;
  tap_t       start_d;

  always_comb begin
    run_d   = run_q + 7'd1;
    start_d = (run_q == 7'd0) ? tap_i : run_start_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      run_q        <= '0;
      best_q       <= '0;
      run_start_q  <= '0;
      best_start_q <= '0;
    end else if (valid_i) begin
      if (good_i) begin
        run_q       <= run_d;
        run_start_q <= start_d;
        if (run_d > best_q) begin
          best_q       <= run_d;
          best_start_q <= start_d;
        end
      end else begin
        run_q <= '0;
      end
    end
  end

  assign best_start_o = best_start_q;
  assign best_len_o   = best_q;

endmodule

// File: rtl/turfio_cin_autotrain.sv
// CIN receive-path auto-trainer: tap sweep, eye centring, bitslip, lock.
// Optional per-tap error counter enabled by TURFIO_AUTOTRAIN_ERRCNT_EN.
module turfio_cin_autotrain
  import turfio_autotrain_pkg::*;
#(
  parameter int          TAP_MAX       = 511,
  parameter int          TAP_STEP      = 8,
  parameter int          MIN_EYE       = 4,
  parameter int          SETTLE_CYCLES = 64,
  parameter int          DWELL_CYCLES  = 4096,
  parameter int          CAPTURE_WAIT  = 64,
  parameter int          LOCK_WAIT     = 1024,
  parameter logic [31:0] TRAIN_PATTERN = 32'hA55A6996
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        idelayctrl_rdy_i,
  input  logic        cin_err_i,
  input  logic        lock_status_i,
  input  logic [31:0] capture_data_i,
  output logic        cin_rst_o,
  output logic        en_vtc_o,
  output logic        delay_load_o,
  output logic [8:0]  delay_cntvaluein_o,
  output logic        capture_req_o,
  output logic        bitslip_rst_o,
  output logic        bitslip_o,
  output logic        lock_req_o,
  output logic        ctrl_active_o,
  output logic        done_o,
  output logic        fail_o,
  output logic [2:0]  fail_code_o,
  output logic [8:0]  eye_start_o,
  output logic [6:0]  eye_len_o,
  output logic [8:0]  tap_o
`ifdef TURFIO_AUTOTRAIN_ERRCNT_EN
  ,
  output logic [15:0] err_count_o,
  output logic [8:0]  err_tap_o
`endif
);

  localparam logic [15:0] SETTLE_M1 = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] DWELL_M1  = 16'(DWELL_CYCLES - 1);
  localparam logic [15:0] CAP_M1    = 16'(CAPTURE_WAIT - 1);
  localparam logic [15:0] LOCK_M1   = 16'(LOCK_WAIT - 1);

  logic [1:0]  rdy_sq, err_sq, lock_sq;
  logic        rdy_s, err_s, lock_s;

  state_t      state_q;
  logic [15:0] cnt_q;
  tap_t        tap_q, dcv_q, eye_start_q;
  logic [6:0]  eye_len_q;
  logic [4:0]  slip_q;
  logic [2:0]  code_q;
  logic        load_q, cin_rst_q, en_vtc_q, cap_q, bs_rst_q;
  logic        bs_q, lreq_q, active_q, done_q, fail_q, err_seen_q;

  tap_t        best_start;
  logic [6:0]  best_len;
  logic [6:0]  half_d;
  logic [9:0]  next_tap_d, ctr_tap_d;
  logic [2:0]  fail_code_d;
  logic        start_ok, eye_valid, eye_good, eye_clr;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      rdy_sq  <= '0;
      err_sq  <= '0;
      lock_sq <= '0;
    end else begin
      rdy_sq  <= {rdy_sq[0], idelayctrl_rdy_i};
      err_sq  <= {err_sq[0], cin_err_i};
      lock_sq <= {lock_sq[0], lock_status_i};
    end
  end

  assign rdy_s  = rdy_sq[1];
  assign err_s  = err_sq[1];
  assign lock_s = lock_sq[1];

  assign start_ok  = start_i && (state_q == S_IDLE ||
                                 state_q == S_DONE ||
                                 state_q == S_FAIL);
  assign eye_clr   = (state_q == S_RST_CIN);
  assign eye_valid = (state_q == S_DWELL) && (cnt_q == 16'd0);
  assign eye_good  = !(err_seen_q || err_s);

  turfio_autotrain_eye u_eye (
    .clk_i        (wb_clk_i),
    .rst_n_i      (wb_rst_n_i),
    .clr_i        (eye_clr),
    .valid_i      (eye_valid),
    .good_i       (eye_good),
    .tap_i        (tap_q),
    .best_start_o (best_start),
    .best_len_o   (best_len)
  );

  always_comb begin
    half_d     = (best_len - 7'd1) >> 1;
    next_tap_d = {1'b0, tap_q} + 10'(TAP_STEP);
    ctr_tap_d  = {1'b0, best_start} + 10'(int'(half_d) * TAP_STEP);
  end

  // Every failure exit is decided here so the FSM only walks success paths.
  always_comb begin
    fail_code_d = FAIL_NONE;
    if (abort_i && state_q != S_IDLE) begin
      fail_code_d = FAIL_ABORT;
    end else begin
      unique case (state_q)
        S_CENTER:
          if (int'(best_len) < MIN_EYE) fail_code_d = FAIL_NO_EYE;
        S_SLIP_CHK:
          if (capture_data_i != TRAIN_PATTERN && slip_q == 5'd31)
            fail_code_d = FAIL_NO_PAT;
        S_LOCK_WAIT:
          if (!lock_s && cnt_q == 16'd0) fail_code_d = FAIL_NO_LOCK;
        S_DONE:
          if (!lock_s && !start_i) fail_code_d = FAIL_LOCK_LOST;
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tap_q       <= '0;
      dcv_q       <= '0;
      eye_start_q <= '0;
      eye_len_q   <= '0;
      slip_q      <= '0;
      code_q      <= FAIL_NONE;
      load_q      <= 1'b0;
      cin_rst_q   <= 1'b0;
      en_vtc_q    <= 1'b1;
      cap_q       <= 1'b0;
      bs_rst_q    <= 1'b0;
      bs_q        <= 1'b0;
      lreq_q      <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      err_seen_q  <= 1'b0;
    end else begin
      load_q <= 1'b0;
      bs_q   <= 1'b0;
      lreq_q <= 1'b0;
      if (fail_code_d != FAIL_NONE) begin
        state_q   <= S_FAIL;
        code_q    <= fail_code_d;
        fail_q    <= 1'b1;
        done_q    <= 1'b0;
        active_q  <= 1'b0;
        en_vtc_q  <= 1'b1;
        cin_rst_q <= 1'b0;
        bs_rst_q  <= 1'b0;
        cap_q     <= 1'b0;
      end else if (start_ok) begin
        state_q     <= S_WAIT_RDY;
        code_q      <= FAIL_NONE;
        fail_q      <= 1'b0;
        done_q      <= 1'b0;
        active_q    <= 1'b1;
        eye_start_q <= '0;
        eye_len_q   <= '0;
      end else begin
        unique case (state_q)
          S_WAIT_RDY:
            if (rdy_s) begin
              state_q   <= S_RST_CIN;
              cnt_q     <= 16'd3;
              cin_rst_q <= 1'b1;
              bs_rst_q  <= 1'b1;
              en_vtc_q  <= 1'b0;
            end
          S_RST_CIN:
            if (cnt_q == 16'd0) begin
              state_q   <= S_SET_TAP;
              cin_rst_q <= 1'b0;
              bs_rst_q  <= 1'b0;
              tap_q     <= '0;
              dcv_q     <= '0;
              load_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          S_SET_TAP: begin
            state_q <= S_SETTLE;
            cnt_q   <= SETTLE_M1;
          end
          S_SETTLE:
            if (cnt_q == 16'd0) begin
              state_q    <= S_DWELL;
              cnt_q      <= DWELL_M1;
              err_seen_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          S_DWELL: begin
            err_seen_q <= err_seen_q | err_s;
            if (cnt_q == 16'd0) state_q <= S_NEXT_TAP;
            else cnt_q <= cnt_q - 16'd1;
          end
          S_NEXT_TAP:
            if (int'(next_tap_d) > TAP_MAX) begin
              state_q <= S_CENTER;
            end else begin
              state_q <= S_SET_TAP;
              tap_q   <= next_tap_d[8:0];
              dcv_q   <= next_tap_d[8:0];
              load_q  <= 1'b1;
            end
          S_CENTER: begin
            state_q     <= S_CTR_SETTLE;
            tap_q       <= ctr_tap_d[8:0];
            dcv_q       <= ctr_tap_d[8:0];
            load_q      <= 1'b1;
            eye_start_q <= best_start;
            eye_len_q   <= best_len;
            cnt_q       <= SETTLE_M1;
            slip_q      <= '0;
          end
          S_CTR_SETTLE, S_SLIP_WAIT:
            if (cnt_q == 16'd0) begin
              state_q <= S_SLIP_CAP;
              cap_q   <= 1'b1;
              cnt_q   <= CAP_M1;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          S_SLIP_CAP:
            if (cnt_q == 16'd0) begin
              state_q <= S_SLIP_CHK;
              cap_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          S_SLIP_CHK:
            if (capture_data_i == TRAIN_PATTERN) begin
              state_q <= S_LOCK;
              lreq_q  <= 1'b1;
            end else begin
              state_q <= S_SLIP_WAIT;
              bs_q    <= 1'b1;
              slip_q  <= slip_q + 5'd1;
              cnt_q   <= 16'd15;
            end
          S_LOCK: begin
            state_q <= S_LOCK_WAIT;
            cnt_q   <= LOCK_M1;
          end
          S_LOCK_WAIT:
            if (lock_s) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              en_vtc_q <= 1'b1;
              active_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          default: ;
        endcase
      end
    end
  end

`ifdef TURFIO_AUTOTRAIN_ERRCNT_EN
  logic [15:0] ecnt_q, ecnt_d, err_count_q;
  tap_t        err_tap_q;

  assign ecnt_d = (err_s && ecnt_q != 16'hFFFF) ? ecnt_q + 16'd1 : ecnt_q;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      ecnt_q      <= '0;
      err_count_q <= '0;
      err_tap_q   <= '0;
    end else if (state_q == S_SETTLE) begin
      ecnt_q <= '0;
    end else if (state_q == S_DWELL) begin
      ecnt_q <= ecnt_d;
      if (cnt_q == 16'd0) begin
        err_count_q <= ecnt_d;
        err_tap_q   <= tap_q;
      end
    end
  end

  assign err_count_o = err_count_q;
  assign err_tap_o   = err_tap_q;
`endif

  assign cin_rst_o          = cin_rst_q;
  assign en_vtc_o           = en_vtc_q;
  assign delay_load_o       = load_q;
  assign delay_cntvaluein_o = dcv_q;
  assign capture_req_o      = cap_q;
  assign bitslip_rst_o      = bs_rst_q;
  assign bitslip_o          = bs_q;
  assign lock_req_o         = lreq_q;
  assign ctrl_active_o      = active_q;
  assign done_o             = done_q;
  assign fail_o             = fail_q;
  assign fail_code_o        = code_q;
  assign eye_start_o        = eye_start_q;
  assign eye_len_o          = eye_len_q;
  assign tap_o              = tap_q;

endmodule

// File: tb/tb_turfio_cin_autotrain.sv
// Directed bench for turfio_cin_autotrain with short timing parameters.
// Models an eye at taps 104..216, a rotating capture word and lock status.
module tb_turfio_cin_autotrain;

  localparam logic [31:0] PAT = 32'hA55A6996;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        rdy = 1'b0;
  logic        cin_err;
  logic        lock_st;
  logic [31:0] cap_data;

  logic        cin_rst, en_vtc, dload, cap_req, bs_rst, bslip, lreq;
  logic        active, done, fail;
  logic [8:0]  dcv, eye_start, tap;
  logic [6:0]  eye_len;
  logic [2:0]  fcode;

  int total = 0;
  int bad = 0;
  int n_load = 0, n_slip = 0, n_lreq = 0, n_cinrst = 0;
  int last_load = 0;
  int slip_k = 0, slip_base = 0, lreq_base = 0, rem;
  logic err_all = 1'b0;
  logic lock_ok = 1'b1;

  always #5 clk = ~clk;

  turfio_cin_autotrain #(
    .TAP_MAX(511), .TAP_STEP(8), .MIN_EYE(4),
    .SETTLE_CYCLES(4), .DWELL_CYCLES(8),
    .CAPTURE_WAIT(4), .LOCK_WAIT(32),
    .TRAIN_PATTERN(PAT)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .start_i(start), .abort_i(abort),
    .idelayctrl_rdy_i(rdy), .cin_err_i(cin_err),
    .lock_status_i(lock_st), .capture_data_i(cap_data),
    .cin_rst_o(cin_rst), .en_vtc_o(en_vtc),
    .delay_load_o(dload), .delay_cntvaluein_o(dcv),
    .capture_req_o(cap_req), .bitslip_rst_o(bs_rst),
    .bitslip_o(bslip), .lock_req_o(lreq),
    .ctrl_active_o(active), .done_o(done),
    .fail_o(fail), .fail_code_o(fcode),
    .eye_start_o(eye_start), .eye_len_o(eye_len),
    .tap_o(tap)
  );

  function automatic logic [31:0] rotl(input logic [31:0] v, input int k);
    if (k == 0) return v;
    return (v << k) | (v >> (32 - k));
  endfunction

  assign cin_err = err_all | ~((tap >= 9'd104) && (tap <= 9'd216));
  assign lock_st = lock_ok && (n_lreq != lreq_base);

  always_comb begin
    rem = slip_k - (n_slip - slip_base);
    if (rem < 0) rem = 0;
    cap_data = rotl(PAT, rem);
  end

  always @(negedge clk) begin
    if (dload) begin
      n_load++;
      last_load = int'(dcv);
    end
    if (bslip) n_slip++;
    if (lreq) n_lreq++;
    if (cin_rst) n_cinrst++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int max);
    int n = 0;
    while (!(done || fail) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("end_timeout", 32'(n < max), 32'd1);
  endtask

  int base_load, base_rst, ld;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_en_vtc", 32'(en_vtc), 32'd1);
    chk("rst_outs", {22'd0, cin_rst, dload, cap_req, bs_rst, bslip,
                     lreq, active, done, fail, 1'b0}, 32'd0);
    chk("rst_tap", 32'(tap), 32'd0);
    rst_n = 1'b1;

    // Training blocked until IDELAYCTRL is ready
    base_load = n_load;
    base_rst  = n_cinrst;
    slip_k = 5; slip_base = n_slip; lreq_base = n_lreq;
    pulse_start();
    chk("start_active", 32'(active), 32'd1);
    repeat (10) @(negedge clk);
    chk("wait_rdy_rst", 32'(cin_rst), 32'd0);
    chk("wait_rdy_load", 32'(n_load - base_load), 32'd0);
    rdy = 1'b1;
    wait_end(3000);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_fail", 32'(fail), 32'd0);
    chk("t1_eye_start", 32'(eye_start), 32'd104);
    chk("t1_eye_len", 32'(eye_len), 32'd15);
    chk("t1_tap", 32'(tap), 32'd160);
    chk("t1_last_load", 32'(last_load), 32'd160);
    chk("t1_loads", 32'(n_load - base_load), 32'd65);
    chk("t1_cinrst_cyc", 32'(n_cinrst - base_rst), 32'd4);
    chk("t3_slips", 32'(n_slip - slip_base), 32'd5);
    chk("t3_lockreq", 32'(n_lreq - lreq_base), 32'd1);
    chk("t1_active", 32'(active), 32'd0);
    chk("t1_en_vtc", 32'(en_vtc), 32'd1);

    // Lock lost while trained
    lock_ok = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4b_fail", 32'(fail), 32'd1);
    chk("t4b_code", 32'(fcode), 32'd4);
    chk("t4b_done", 32'(done), 32'd0);

    // No eye at all
    lock_ok = 1'b1;
    err_all = 1'b1;
    pulse_start();
    wait_end(3000);
    chk("t2_fail", 32'(fail), 32'd1);
    chk("t2_code", 32'(fcode), 32'd1);
    chk("t2_active", 32'(active), 32'd0);
    chk("t2_en_vtc", 32'(en_vtc), 32'd1);
    chk("t2_cin_rst", 32'(cin_rst), 32'd0);
    chk("t2_eye_len", 32'(eye_len), 32'd0);

    // Lock never arrives
    err_all = 1'b0;
    lock_ok = 1'b0;
    slip_k = 0; slip_base = n_slip; lreq_base = n_lreq;
    pulse_start();
    wait_end(3000);
    chk("t4_code", 32'(fcode), 32'd3);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_slips", 32'(n_slip - slip_base), 32'd0);
    chk("t4_lockreq", 32'(n_lreq - lreq_base), 32'd1);

    // Abort with simultaneous start while dwelling at tap 40
    lock_ok = 1'b1;
    lreq_base = n_lreq;
    pulse_start();
    begin
      int n = 0;
      while (tap != 9'd40 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("t5_reach40", 32'(n < 2000), 32'd1);
    end
    repeat (6) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("t5_fail", 32'(fail), 32'd1);
    chk("t5_code", 32'(fcode), 32'd5);
    chk("t5_active", 32'(active), 32'd0);
    ld = n_load;
    repeat (20) @(negedge clk);
    chk("t5_no_load", 32'(n_load - ld), 32'd0);
    chk("t5_tap", 32'(tap), 32'd40);

    // Reset during bitslip capture, then retrain
    slip_k = 3; slip_base = n_slip; lreq_base = n_lreq;
    pulse_start();
    begin
      int n = 0;
      while (!cap_req && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("t6_reach_cap", 32'(n < 3000), 32'd1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_outs", {22'd0, cin_rst, dload, cap_req, bs_rst, bslip,
                        lreq, active, done, fail, 1'b0}, 32'd0);
    chk("t6_rst_en_vtc", 32'(en_vtc), 32'd1);
    chk("t6_rst_tap", 32'(tap), 32'd0);
    chk("t6_rst_eye", {16'd0, eye_start, eye_len}, 32'd0);
    rst_n = 1'b1;
    slip_k = 2; slip_base = n_slip; lreq_base = n_lreq;
    pulse_start();
    begin
      int n = 0;
      while (!dload && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("t6_first_load", 32'(n < 50), 32'd1);
    end
    chk("t6_first_tap", 32'(dcv), 32'd0);
    wait_end(3000);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_eye_start", 32'(eye_start), 32'd104);
    chk("t6_slips", 32'(n_slip - slip_base), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
